// File: rtl/game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : game_ctrl_if
//  Purpose  : Bundles the frame-timing, start, paddle and ball/status signals
//             exchanged between the game controller and its environment.
//  Ports    : i_ani_stb, i_animate, i_start_btn, i_pad_x1/x2/y1 (to the ctrl)
//             o_x1/x2/y1/y2, o_state, o_score, o_lives, o_hit, o_game_over
//             (from the ctrl)
//  Revision : 1.0  initial release
// ============================================================================
interface game_ctrl_if;
    logic        i_ani_stb;
    logic        i_animate;
    logic        i_start_btn;
    logic [11:0] i_pad_x1;
    logic [11:0] i_pad_x2;
    logic [11:0] i_pad_y1;
    logic [11:0] o_x1;
    logic [11:0] o_x2;
    logic [11:0] o_y1;
    logic [11:0] o_y2;
    logic [1:0]  o_state;
    logic [7:0]  o_score;
    logic [1:0]  o_lives;
    logic        o_hit;
    logic        o_game_over;

    // Controller side
    modport slave (
        input  i_ani_stb, i_animate, i_start_btn, i_pad_x1, i_pad_x2, i_pad_y1,
        output o_x1, o_x2, o_y1, o_y2, o_state, o_score, o_lives, o_hit, o_game_over
    );

    // Environment side
    modport master (
        output i_ani_stb, i_animate, i_start_btn, i_pad_x1, i_pad_x2, i_pad_y1,
        input  o_x1, o_x2, o_y1, o_y2, o_state, o_score, o_lives, o_hit, o_game_over
    );
endinterface
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_ctrl
//  Purpose  : Single-ball paddle game controller: serve countdown, ball motion
//             with wall and paddle bounces, score and lives bookkeeping.
//  Ports    : i_clk  - clock
//             i_rst  - synchronous active-high reset
//             bus    - game_ctrl_if.slave (frame strobes, start, paddle box in;
//                      ball box, state, score, lives, hit, game-over out)
//  Revision : 1.0  initial release
// ============================================================================
module game_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int B_SIZE       = 8,
    parameter int SPEED        = 2,
    parameter int IX           = 316,
    parameter int IY           = 200,
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  wire logic  i_clk,
    input  wire logic  i_rst,
    game_ctrl_if.slave bus
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_SERVE = 2'd1;
    localparam logic [1:0]  c_ST_PLAY  = 2'd2;
    localparam logic [1:0]  c_ST_OVER  = 2'd3;

    localparam logic [11:0] c_IX     = 12'(IX);
    localparam logic [11:0] c_IY     = 12'(IY);
    localparam logic [11:0] c_STEP   = 12'(SPEED);
    localparam logic [11:0] c_BSZ12  = 12'(B_SIZE);
    // Collision arithmetic is done one bit wider so box sums cannot wrap.
    localparam logic [12:0] c_BSZ    = 13'(B_SIZE);
    localparam logic [12:0] c_SPD    = 13'(SPEED);
    localparam logic [12:0] c_MISS_Y = 13'(SCREEN_H - B_SIZE);
    localparam logic [12:0] c_RWALL  = 13'(SCREEN_W - SPEED);
    localparam logic [1:0]  c_LIVES  = 2'(LIVES);
    localparam logic [15:0] c_SERVE  = 16'(SERVE_FRAMES);

    logic [1:0]  r_state, w_state_nxt;
    logic [11:0] r_bx, w_bx_nxt;
    logic [11:0] r_by, w_by_nxt;
    logic [11:0] r_x2, r_y2;
    logic        r_dx_neg, w_dx_neg_nxt;   // 1: moving left
    logic        r_dy_neg, w_dy_neg_nxt;   // 1: moving up
    logic [7:0]  r_score, w_score_nxt;
    logic [1:0]  r_lives, w_lives_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_hit, w_hit_nxt;
    logic        r_game_over;

    logic        w_tick;
    logic [12:0] w_bx_end, w_by_end, w_pad_y1;
    logic        w_miss, w_paddle, w_wall_l, w_wall_r, w_wall_t;

    assign w_tick   = bus.i_animate & bus.i_ani_stb;
    assign w_bx_end = {1'b0, r_bx} + c_BSZ;
    assign w_by_end = {1'b0, r_by} + c_BSZ;
    assign w_pad_y1 = {1'b0, bus.i_pad_y1};

    assign w_miss   = {1'b0, r_by} >= c_MISS_Y;
    // Ball bottom must cross into the paddle's top SPEED-pixel band while falling.
    assign w_paddle = !r_dy_neg
                      && (w_by_end >= w_pad_y1)
                      && (w_by_end <  w_pad_y1 + c_SPD)
                      && (w_bx_end >  {1'b0, bus.i_pad_x1})
                      && (r_bx     <  bus.i_pad_x2);
    assign w_wall_l = {1'b0, r_bx} < c_SPD;
    assign w_wall_r = w_bx_end > c_RWALL;
    assign w_wall_t = {1'b0, r_by} < c_SPD;

    always_comb begin
        w_state_nxt  = r_state;
        w_bx_nxt     = r_bx;
        w_by_nxt     = r_by;
        w_dx_neg_nxt = r_dx_neg;
        w_dy_neg_nxt = r_dy_neg;
        w_score_nxt  = r_score;
        w_lives_nxt  = r_lives;
        w_cnt_nxt    = r_cnt;
        w_hit_nxt    = 1'b0;

        case (r_state)
            c_ST_IDLE, c_ST_OVER: begin
                if (bus.i_start_btn) begin
                    w_state_nxt = c_ST_SERVE;
                    w_score_nxt = 8'd0;
                    w_lives_nxt = c_LIVES;
                    w_cnt_nxt   = c_SERVE;
                end
            end
            c_ST_SERVE: begin
                w_dx_neg_nxt = 1'b0;
                w_dy_neg_nxt = 1'b0;
                if (w_tick) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                    if (r_cnt == 16'd1) begin
                        w_state_nxt = c_ST_PLAY;
                    end
                end
            end
            c_ST_PLAY: begin
                if (w_tick) begin
                    if (w_miss) begin
                        w_lives_nxt = r_lives - 2'd1;
                        if (r_lives == 2'd1) begin
                            w_state_nxt = c_ST_OVER;
                        end else begin
                            w_state_nxt = c_ST_SERVE;
                            w_cnt_nxt   = c_SERVE;
                        end
                    end else begin
                        if (w_paddle) begin
                            w_dy_neg_nxt = 1'b1;
                            w_hit_nxt    = 1'b1;
                            if (r_score != 8'hFF) begin
                                w_score_nxt = r_score + 8'd1;
                            end
                        end
                        // Walls are applied after the paddle so a corner hit
                        // still bounces off the playfield edge.
                        if (w_wall_l) w_dx_neg_nxt = 1'b0;
                        if (w_wall_r) w_dx_neg_nxt = 1'b1;
                        if (w_wall_t) w_dy_neg_nxt = 1'b0;
                        w_bx_nxt = w_dx_neg_nxt ? r_bx - c_STEP : r_bx + c_STEP;
                        w_by_nxt = w_dy_neg_nxt ? r_by - c_STEP : r_by + c_STEP;
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase

        // The ball always sits at the serve point whenever a serve is pending.
        if (w_state_nxt == c_ST_SERVE) begin
            w_bx_nxt = c_IX;
            w_by_nxt = c_IY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_ST_IDLE;
            r_bx        <= c_IX;
            r_by        <= c_IY;
            r_x2        <= c_IX + c_BSZ12;
            r_y2        <= c_IY + c_BSZ12;
            r_dx_neg    <= 1'b0;
            r_dy_neg    <= 1'b0;
            r_score     <= 8'd0;
            r_lives     <= c_LIVES;
            r_cnt       <= 16'd0;
            r_hit       <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bx        <= w_bx_nxt;
            r_by        <= w_by_nxt;
            r_x2        <= w_bx_nxt + c_BSZ12;
            r_y2        <= w_by_nxt + c_BSZ12;
            r_dx_neg    <= w_dx_neg_nxt;
            r_dy_neg    <= w_dy_neg_nxt;
            r_score     <= w_score_nxt;
            r_lives     <= w_lives_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hit       <= w_hit_nxt;
            r_game_over <= (w_state_nxt == c_ST_OVER);
        end
    end

    assign bus.o_x1        = r_bx;
    assign bus.o_x2        = r_x2;
    assign bus.o_y1        = r_by;
    assign bus.o_y2        = r_y2;
    assign bus.o_state     = r_state;
    assign bus.o_score     = r_score;
    assign bus.o_lives     = r_lives;
    assign bus.o_hit       = r_hit;
    assign bus.o_game_over = r_game_over;

endmodule
`default_nettype wire
